// File: rtl/cam_ddr_wr_arbiter.sv
// cam_ddr_wr_arbiter: round-robins two camera line FIFOs into fixed-length DDR write bursts,
// one address command per burst. Optional macro FRAME_PINGPONG_EN adds per-channel frame banks.
module cam_ddr_wr_arbiter #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 28,
    parameter int unsigned BURST_LEN   = 64,
    parameter int unsigned FRAME_BEATS = 115200,
    parameter int unsigned CH0_BASE    = 0,
    parameter int unsigned CH1_BASE    = 'h80000
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              ch0_req,
    input  logic              ch0_frame_start,
    input  logic [DATA_W-1:0] ch0_rd_data,
    output logic              ch0_rd_en,
    output logic              ch0_bank,
    input  logic              ch1_req,
    input  logic              ch1_frame_start,
    input  logic [DATA_W-1:0] ch1_rd_data,
    output logic              ch1_rd_en,
    output logic              ch1_bank,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_last,
    output logic              grant,
    output logic              busy
);
    localparam int unsigned       CNT_W      = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(FRAME_BEATS);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              rr_last_q, rr_last_d;
    logic [CNT_W-1:0]  beat_q, beat_d;

    logic [1:0]        req;
    logic [1:0]        fs;
    logic [1:0]        rd_en;
    logic [1:0]        bank;
    logic [DATA_W-1:0] rd_data  [2];
    logic [ADDR_W-1:0] base     [2];
    logic [ADDR_W-1:0] ptr      [2];
    logic [ADDR_W-1:0] bank_off [2];
    logic              in_burst;
    logic              burst_end;

    assign req        = {ch1_req, ch0_req};
    assign fs         = {ch1_frame_start, ch0_frame_start};
    assign rd_data[0] = ch0_rd_data;
    assign rd_data[1] = ch1_rd_data;
    assign base[0]    = ADDR_W'(CH0_BASE);
    assign base[1]    = ADDR_W'(CH1_BASE);

    assign in_burst  = (state_q != S_IDLE);
    assign burst_end = (state_q == S_DATA) && wr_ready && (beat_q == LAST_BEAT);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b0;
            rr_last_q <= 1'b1;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            beat_q    <= beat_d;
        end
    end

    // On a tie the channel not served last wins; a lone requester always wins.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        beat_d    = beat_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d   = (&req) ? ~rr_last_q : req[1];
                    rr_last_d = grant_d;
                    beat_d    = '0;
                    state_d   = S_CMD;
                end
            end
            S_CMD: begin
                if (cmd_ready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (wr_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        wr_last   = 1'b0;
        rd_en     = '0;
        unique case (state_q)
            S_CMD: begin
                cmd_valid = 1'b1;
                cmd_addr  = base[grant_q] + bank_off[grant_q] + ptr[grant_q];
            end
            S_DATA: begin
                wr_valid       = 1'b1;
                wr_data        = rd_data[grant_q];
                wr_last        = (beat_q == LAST_BEAT);
                rd_en[grant_q] = wr_ready;
            end
            default: ;
        endcase
    end

    // Per-channel pointer, bank and deferred frame-start bookkeeping.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        localparam logic CH = 1'(gi);

        logic [ADDR_W-1:0] ptr_q, ptr_d;
        logic              pend_q, pend_d;
        logic              bank_q, bank_d;
        logic              owns;
        logic              restart;

        assign owns = in_burst && (grant_q == CH);

        // A frame start seen while this channel owns a burst is deferred to the burst end.
        always_comb begin
            ptr_d   = ptr_q;
            pend_d  = pend_q;
            restart = 1'b0;
            if (owns && burst_end) begin
                if (fs[gi] || pend_q) begin
                    restart = 1'b1;
                    pend_d  = 1'b0;
                end else if (ptr_q + BURST_STEP == FRAME_SIZE) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = ptr_q + BURST_STEP;
                end
            end else if (fs[gi]) begin
                if (owns) begin
                    pend_d = 1'b1;
                end else begin
                    restart = 1'b1;
                end
            end
            if (restart) begin
                ptr_d = '0;
            end
        end

`ifdef FRAME_PINGPONG_EN
        assign bank_d          = bank_q ^ restart;
        assign bank_off[gi]    = bank_q ? FRAME_SIZE : '0;
`else
        assign bank_d          = 1'b0;
        assign bank_off[gi]    = '0;
`endif

        always_ff @(posedge sys_clk) begin
            if (rst) begin
                ptr_q  <= '0;
                pend_q <= 1'b0;
                bank_q <= 1'b0;
            end else begin
                ptr_q  <= ptr_d;
                pend_q <= pend_d;
                bank_q <= bank_d;
            end
        end

        assign ptr[gi]  = ptr_q;
        assign bank[gi] = bank_q;
    end

    assign ch0_rd_en = rd_en[0];
    assign ch1_rd_en = rd_en[1];
    assign ch0_bank  = bank[0];
    assign ch1_bank  = bank[1];
    assign grant     = grant_q;
    assign busy      = in_burst;

endmodule

// File: tb/tb_cam_ddr_wr_arbiter.sv
// Bench for cam_ddr_wr_arbiter: directed scenarios with literal address/grant expectations,
// then randomized traffic checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_cam_ddr_wr_arbiter;
    localparam int BL = 4;
    localparam int FB = 16;
    localparam int DW = 16;
    localparam int AW = 28;
    localparam int B0 = 0;
    localparam int B1 = 'h1000;
`ifdef FRAME_PINGPONG_EN
    localparam int PP = 1;
`else
    localparam int PP = 0;
`endif

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic          ch0_req = 1'b0, ch1_req = 1'b0;
    logic          ch0_frame_start = 1'b0, ch1_frame_start = 1'b0;
    logic [DW-1:0] ch0_rd_data = '0, ch1_rd_data = '0;
    logic          ch0_rd_en, ch1_rd_en, ch0_bank, ch1_bank;
    logic          cmd_valid, cmd_ready = 1'b0;
    logic [AW-1:0] cmd_addr;
    logic          wr_valid, wr_ready = 1'b0;
    logic [DW-1:0] wr_data;
    logic          wr_last, grant, busy;

    always #5 sys_clk = ~sys_clk;

    cam_ddr_wr_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .FRAME_BEATS(FB),
        .CH0_BASE(B0), .CH1_BASE(B1)
    ) dut (
        .sys_clk(sys_clk), .rst(rst),
        .ch0_req(ch0_req), .ch0_frame_start(ch0_frame_start), .ch0_rd_data(ch0_rd_data),
        .ch0_rd_en(ch0_rd_en), .ch0_bank(ch0_bank),
        .ch1_req(ch1_req), .ch1_frame_start(ch1_frame_start), .ch1_rd_data(ch1_rd_data),
        .ch1_rd_en(ch1_rd_en), .ch1_bank(ch1_bank),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
        .grant(grant), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model: phase 0 = waiting, 1 = address offered, 2 = streaming beats.
    bit m_valid = 1'b0;
    int m_phase, m_grant, m_last, m_beats;
    int m_ptr[2], m_bank[2];
    bit m_pend[2];

    int cmd_addr_log[$];
    int cmd_grant_log[$];
    int pop_cnt[2];
    int beats_seen, lasts_seen;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin : compare_proc
        logic [52:0] exp_v, act_v;
        int          e_addr;
        logic [DW-1:0] e_wd;
        bit          e_cv, e_wv, e_last, e_re0, e_re1, fin, mine;
        bit          fsv[2];

        e_cv   = (m_phase == 1);
        e_wv   = (m_phase == 2);
        e_addr = e_cv ? ((m_grant == 1 ? B1 : B0) + m_bank[m_grant] * FB + m_ptr[m_grant]) : 0;
        e_wd   = e_wv ? (m_grant == 1 ? ch1_rd_data : ch0_rd_data) : '0;
        e_last = e_wv && (m_beats == BL - 1);
        e_re0  = e_wv && (m_grant == 0) && wr_ready;
        e_re1  = e_wv && (m_grant == 1) && wr_ready;
        exp_v  = {e_cv, AW'(e_addr), e_wv, e_wd, e_last, e_re0, e_re1,
                  m_bank[0] != 0, m_bank[1] != 0, m_grant != 0, m_phase != 0};
        act_v  = {cmd_valid, cmd_addr, wr_valid, wr_data, wr_last, ch0_rd_en, ch1_rd_en,
                  ch0_bank, ch1_bank, grant, busy};
        if (m_valid) begin
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_outputs t=%0t act=%h exp=%h (cv,addr,wv,data,last,re0,re1,b0,b1,grant,busy)",
                         $time, act_v, exp_v);
            end
        end

        if (cmd_valid && cmd_ready) begin
            cmd_addr_log.push_back(int'(cmd_addr));
            cmd_grant_log.push_back(int'(grant));
        end
        if (ch0_rd_en) pop_cnt[0]++;
        if (ch1_rd_en) pop_cnt[1]++;
        if (wr_valid && wr_ready) beats_seen++;
        if (wr_valid && wr_ready && wr_last) lasts_seen++;

        // Advance the model by the coming rising edge using the inputs now stable.
        if (rst) begin
            m_valid = 1'b1;
            m_phase = 0; m_grant = 0; m_last = 1; m_beats = 0;
            for (int c = 0; c < 2; c++) begin
                m_ptr[c] = 0; m_bank[c] = 0; m_pend[c] = 1'b0;
            end
        end else begin
            fsv[0] = ch0_frame_start;
            fsv[1] = ch1_frame_start;
            fin = (m_phase == 2) && wr_ready && (m_beats == BL - 1);
            for (int c = 0; c < 2; c++) begin
                mine = (m_phase != 0) && (m_grant == c);
                if (fin && mine) begin
                    if (fsv[c] || m_pend[c]) begin
                        m_ptr[c] = 0; m_bank[c] ^= PP; m_pend[c] = 1'b0;
                    end else begin
                        m_ptr[c] = (m_ptr[c] + BL) % FB;
                    end
                end else if (fsv[c]) begin
                    if (mine) m_pend[c] = 1'b1;
                    else begin m_ptr[c] = 0; m_bank[c] ^= PP; end
                end
            end
            if (m_phase == 0) begin
                if (ch0_req || ch1_req) begin
                    m_grant = (ch0_req && ch1_req) ? 1 - m_last : (ch0_req ? 0 : 1);
                    m_last  = m_grant;
                    m_phase = 1;
                    m_beats = 0;
                end
            end else if (m_phase == 1) begin
                if (cmd_ready) m_phase = 2;
            end else if (wr_ready) begin
                if (m_beats == BL - 1) m_phase = 0;
                else m_beats++;
            end
        end
    end

    // One clock; the FWFT FIFO heads advance only when popped.
    task automatic step();
        bit p0, p1;
        @(negedge sys_clk);
        p0 = ch0_rd_en;
        p1 = ch1_rd_en;
        @(posedge sys_clk);
        #2;
        if (p0) ch0_rd_data = DW'($urandom);
        if (p1) ch1_rd_data = DW'($urandom);
    endtask

    task automatic clear_logs();
        cmd_addr_log.delete();
        cmd_grant_log.delete();
        pop_cnt[0] = 0; pop_cnt[1] = 0;
        beats_seen = 0; lasts_seen = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ch0_req = 1'b0; ch1_req = 1'b0;
        ch0_frame_start = 1'b0; ch1_frame_start = 1'b0;
        cmd_ready = 1'b1; wr_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic run_until_cmds(input int n);
        int budget = 300;
        while (cmd_addr_log.size() < n && budget > 0) begin
            step();
            budget--;
        end
        if (cmd_addr_log.size() < n) begin
            checks++; failures++;
            $display("FAIL cmd_timeout act=%0d exp=%0d", cmd_addr_log.size(), n);
        end
    endtask

    task automatic wait_idle();
        int budget = 300;
        while (busy && budget > 0) begin
            step();
            budget--;
        end
        if (busy) begin
            checks++; failures++;
            $display("FAIL idle_timeout act=1 exp=0");
        end
    endtask

    function automatic int log_at(input int i);
        return (i < cmd_addr_log.size()) ? cmd_addr_log[i] : -1;
    endfunction

    function automatic int grant_at(input int i);
        return (i < cmd_grant_log.size()) ? cmd_grant_log[i] : -1;
    endfunction

    initial begin
        int k;
        int exp_addr[5];
        ch0_rd_data = DW'($urandom);
        ch1_rd_data = DW'($urandom);

        // Reset state and ch0-only bursts.
        do_reset();
        check("reset_busy", busy, 0);
        check("reset_grant", grant, 0);
        ch0_req = 1'b1;
        run_until_cmds(2);
        ch0_req = 1'b0;
        wait_idle();
        check("s1_addr0", log_at(0), 'h0);
        check("s1_addr1", log_at(1), 'h4);
        check("s1_pops", pop_cnt[0], 8);
        check("s1_lasts", lasts_seen, 2);

        // Both requesting: alternating grants.
        do_reset();
        ch0_req = 1'b1; ch1_req = 1'b1;
        run_until_cmds(4);
        ch0_req = 1'b0; ch1_req = 1'b0;
        wait_idle();
        check("s2_grant0", grant_at(0), 0);
        check("s2_grant1", grant_at(1), 1);
        check("s2_grant2", grant_at(2), 0);
        check("s2_grant3", grant_at(3), 1);
        check("s2_addr0", log_at(0), 'h0);
        check("s2_addr1", log_at(1), 'h1000);
        check("s2_addr2", log_at(2), 'h4);
        check("s2_addr3", log_at(3), 'h1004);

        // Alternating wr_ready stalls.
        do_reset();
        ch0_req = 1'b1;
        run_until_cmds(1);
        ch0_req = 1'b0;
        k = 0;
        while (busy && k < 50) begin
            wr_ready = (k % 2 == 0);
            step();
            k++;
        end
        wr_ready = 1'b1;
        check("s3_data_cycles", k, 7);
        check("s3_ch0_pops", pop_cnt[0], 4);
        check("s3_ch1_pops", pop_cnt[1], 0);

        // Pointer wrap over five bursts.
        do_reset();
        ch0_req = 1'b1;
        run_until_cmds(5);
        ch0_req = 1'b0;
        wait_idle();
        exp_addr = '{'h0, 'h4, 'h8, 'hC, 'h0};
        for (int i = 0; i < 5; i++) check($sformatf("s4_addr%0d", i), log_at(i), exp_addr[i]);

        // Frame start while ch0 streams the burst at 0x8.
        do_reset();
        ch0_req = 1'b1;
        run_until_cmds(3);
        ch0_frame_start = 1'b1;
        step();
        ch0_frame_start = 1'b0;
        run_until_cmds(4);
        ch0_req = 1'b0;
        wait_idle();
        check("s5_addr2", log_at(2), 'h8);
        check("s5_addr3", log_at(3), PP ? 'h10 : 'h0);
        check("s5_ch0_bank", ch0_bank, PP);
        check("s5_ch1_bank", ch1_bank, 0);

        // Reset during the third data beat.
        do_reset();
        ch0_req = 1'b1;
        run_until_cmds(1);
        step(); step();
        rst = 1'b1;
        step();
        check("s6_outputs_zero",
              longint'({cmd_valid, cmd_addr, wr_valid, wr_data, wr_last, ch0_rd_en,
                        ch1_rd_en, ch0_bank, ch1_bank, grant, busy}), 0);
        check("s6_no_last", lasts_seen, 0);
        rst = 1'b0;
        ch0_req = 1'b0; ch1_req = 1'b1;
        clear_logs();
        run_until_cmds(1);
        ch1_req = 1'b0;
        wait_idle();
        check("s6_ch1_addr", log_at(0), 'h1000);
        check("s6_ch1_grant", grant_at(0), 1);

        // Randomized traffic, checked every cycle by the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            rst             = ($urandom_range(0, 399) == 0);
            ch0_req         = ($urandom_range(0, 3) != 0);
            ch1_req         = ($urandom_range(0, 2) != 0);
            ch0_frame_start = ($urandom_range(0, 15) == 0);
            ch1_frame_start = ($urandom_range(0, 15) == 0);
            cmd_ready       = ($urandom_range(0, 9) < 7);
            wr_ready        = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0;
        ch0_req = 1'b0; ch1_req = 1'b0;
        ch0_frame_start = 1'b0; ch1_frame_start = 1'b0;
        cmd_ready = 1'b1; wr_ready = 1'b1;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
